// File: rtl/serializer_pkg.sv
// Shared types and constants for the parallel-to-serial front end of the
// sequence detector.
package serializer_pkg;

  // Default word width, also used by the detector bench.
  localparam int DEFAULT_WIDTH = 8;

  // Shifter state: waiting for a word, or streaming one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Width of a counter that indexes the bits of a width-bit word.
  function automatic int CNT_W(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register with a valid/ready input side. The shifter
// empties it by pulsing take while pend_full is high.
module ser_hold_reg
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic [WIDTH-1:0] pend_data,
  output logic             pend_full
);

  // Ready only when empty. It is held low during reset so that no word
  // slips in on the edge that clears the register.
  assign in_ready = ~pend_full & ~reset;

  // Capture a word on accept. It is released when the shifter takes it.
  // Accept and take never coincide, because they need opposite pend_full.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_full <= 1'b0;
      pend_data <= '0;
    end else if (in_valid && in_ready) begin
      pend_data <= in_data;
      pend_full <= 1'b1;
    end else if (take) begin
      pend_full <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector's din. Words
// arrive over valid/ready and leave one bit per clock. A holding register
// allows back-to-back words with no idle bit between them.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last
);

  localparam int             CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] pend_data;
  logic             pend_full;
  logic             take;

  // Bit of a word that sits at the output end of the shifter.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit into the output position, filling with zeros.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // The shifter takes the pending word when it is idle or sending the
  // final bit of the current word. The registered last flag equals
  // bit_cnt == WIDTH-1 while shifting and is always 0 in IDLE.
  assign take = pend_full & ((state == IDLE) | last);

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .take     (take),
    .pend_data(pend_data),
    .pend_full(pend_full)
  );

  // State machine, shifter, bit counter and registered outputs. Each
  // branch computes the output bits for the next cycle directly, so
  // dout, dout_valid and last all come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
      last       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_full) begin
            state      <= SHIFT;
            shreg      <= pend_data;
            bit_cnt    <= '0;
            dout       <= out_bit(pend_data);
            dout_valid <= 1'b1;
            last       <= 1'b0;
          end else begin
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            last       <= 1'b0;
          end
        end
        SHIFT: begin
          if (!last) begin
            shreg      <= shift_word(shreg);
            bit_cnt    <= bit_cnt + CNT_ONE;
            dout       <= out_bit(shift_word(shreg));
            dout_valid <= 1'b1;
            last       <= ((bit_cnt + CNT_ONE) == LAST_IDX);
          end else if (pend_full) begin
            shreg      <= pend_data;
            bit_cnt    <= '0;
            dout       <= out_bit(pend_data);
            dout_valid <= 1'b1;
            last       <= 1'b0;
          end else begin
            state      <= IDLE;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            last       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          dout       <= IDLE_BIT;
          dout_valid <= 1'b0;
          last       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer. Two instances share the same
// input stream: one sends MSB first with idle level 0, and the other sends
// LSB first with idle level 1. A queue-based model predicts every output.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;

  logic ready_m, dout_m, valid_m, last_m;
  logic ready_l, dout_l, valid_l, last_l;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: the pending word plus a queue of bits still to appear
  // on dout for each bit order. The head of each queue is the bit being
  // shown in the current cycle.
  bit           m_pend_full;
  logic [W-1:0] m_pend_word;
  bit           q_msb[$];
  bit           q_lsb[$];
  bit           m_accepted;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_m), .dout(dout_m), .dout_valid(valid_m), .last(last_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_l), .dout(dout_l), .dout_valid(valid_l), .last(last_l)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one rising edge, using the inputs the bench drove.
  task automatic modelEdge();
    bit pf0;
    pf0 = m_pend_full;
    m_accepted = 1'b0;
    if (reset) begin
      q_msb.delete();
      q_lsb.delete();
      m_pend_full = 1'b0;
    end else begin
      if (q_msb.size() > 0) begin
        void'(q_msb.pop_front());
        void'(q_lsb.pop_front());
      end
      if (q_msb.size() == 0 && pf0) begin
        for (int i = W - 1; i >= 0; i--) q_msb.push_back(m_pend_word[i]);
        for (int i = 0; i < W; i++) q_lsb.push_back(m_pend_word[i]);
        m_pend_full = 1'b0;
      end
      if (in_valid && !pf0) begin
        m_pend_word = in_data;
        m_pend_full = 1'b1;
        m_accepted  = 1'b1;
      end
    end
  endtask

  // Compare the registered outputs of both instances with the model.
  task automatic checkModel();
    bit ev;
    ev = (q_msb.size() > 0);
    checkOutput("valid_msb", 32'(valid_m), 32'(ev));
    checkOutput("valid_lsb", 32'(valid_l), 32'(ev));
    checkOutput("dout_msb", 32'(dout_m), 32'(ev ? q_msb[0] : 1'b0));
    checkOutput("dout_lsb", 32'(dout_l), 32'(ev ? q_lsb[0] : 1'b1));
    checkOutput("last_msb", 32'(last_m), 32'(q_msb.size() == 1));
    checkOutput("last_lsb", 32'(last_l), 32'(q_lsb.size() == 1));
  endtask

  // Drive one cycle of inputs, check in_ready, clock, then check outputs.
  task automatic applyStimulus(input bit rst, input bit v, input logic [W-1:0] d);
    reset    = rst;
    in_valid = v;
    in_data  = d;
    #1;
    checkOutput("in_ready_msb", 32'(ready_m), 32'(!m_pend_full && !rst));
    checkOutput("in_ready_lsb", 32'(ready_l), 32'(!m_pend_full && !rst));
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkModel();
  endtask

  initial begin
    logic [W-1:0] word;
    logic [W-1:0] words[3];
    int idx;
    int run;
    int best_run;
    bit sent;

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    m_pend_full = 1'b0;
    m_pend_word = '0;
    m_accepted  = 1'b0;
    @(negedge clk);

    // Reset state.
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    checkOutput("rst_valid", 32'(valid_m), 32'(0));
    checkOutput("rst_dout_lsb_idle", 32'(dout_l), 32'(1));

    // Single word 8'hB2: fixed bit sequences in both orders, last on bit 8.
    word = 8'hB2;
    applyStimulus(1'b0, 1'b1, word);
    for (int k = 0; k < W; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("b2_msb_bit", 32'(dout_m), 32'(word[W-1-k]));
      checkOutput("b2_lsb_bit", 32'(dout_l), 32'(word[k]));
      checkOutput("b2_last", 32'(last_m), 32'(k == W - 1));
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("b2_end_valid", 32'(valid_m), 32'(0));
    checkOutput("b2_end_idle_msb", 32'(dout_m), 32'(0));
    checkOutput("b2_end_idle_lsb", 32'(dout_l), 32'(1));

    // Back-to-back A5, 3C, then 5A under backpressure: one gapless run.
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'h5A;
    idx = 0;
    run = 0;
    best_run = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, idx < 3, (idx < 3) ? words[idx] : 8'h00);
      if (m_accepted) idx++;
      if (valid_m) run++;
      else run = 0;
      if (run > best_run) best_run = run;
    end
    checkOutput("b2b_words_accepted", 32'(idx), 32'(3));
    checkOutput("b2b_gapless_run", 32'(best_run), 32'(3 * W));

    // Reset while bit 4 of 8'hFF is shown, with 8'h00 pending.
    sent = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'hFF);
    for (int c = 0; c < 20 && q_msb.size() != 4; c++) begin
      applyStimulus(1'b0, !sent, 8'h00);
      if (m_accepted) sent = 1'b1;
    end
    checkOutput("mid_reached_bit4", 32'(q_msb.size()), 32'(4));
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("mid_rst_valid", 32'(valid_m), 32'(0));
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("post_rst_valid", 32'(valid_m), 32'(0));
    end

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
                    W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
